// File: rtl/mult_accumulator_pkg.sv
// Shared types and helpers for the product-stream accumulator.
package mult_accumulator_pkg;

    // Issue-side tag carried alongside each product through the latency line.
    localparam int unsigned BEAT_W = 2;

    typedef struct packed {
        logic valid;
        logic last;
    } beat_t;

    // Bits needed to count in-flight frame ends, 0..latency+1.
    function automatic int unsigned cnt_width(input int unsigned latency);
        return $clog2(latency + 2);
    endfunction

endpackage

// File: rtl/mult_valid_delay.sv
// Fixed-depth shift register that aligns issue tags with multiplier products.
module mult_valid_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : g_pass
        // Zero-latency multiplier: tags line up with the product in the same cycle.
        logic unused_ok;
        assign unused_ok = ^{clk, rst};
        assign data_o    = data_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift tags one stage per cycle; reset flushes everything in flight.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= data_i;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign data_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/mult_accumulator.sv
// Sums framed bursts of signed products into one result per frame.
module mult_accumulator
    import mult_accumulator_pkg::*;
#(
    parameter int unsigned P_WIDTH   = 7,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned LATENCY   = 1,
    parameter string       SATURATE  = "FALSE"
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 i_valid,
    input  logic                 i_last,
    output logic                 i_ready,
    input  logic [P_WIDTH-1:0]   i_p,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_ovf
);

    localparam bit          SAT_EN = (SATURATE == "TRUE");
    localparam int unsigned CNT_W  = cnt_width(LATENCY);
    localparam int unsigned EXT_W  = ACC_WIDTH + 1;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic                 accept;
    logic                 last_in;
    logic                 frame_end;
    beat_t                beat_in;
    beat_t                beat_d;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 first_q, first_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     lastcnt_q, lastcnt_d;
    logic                 o_valid_q, o_valid_d;
    logic [ACC_WIDTH-1:0] o_sum_q, o_sum_d;
    logic                 o_ovf_q, o_ovf_d;

    logic [EXT_W-1:0]     p_ext;
    logic [EXT_W-1:0]     base_ext;
    logic [EXT_W-1:0]     sum_ext;
    logic                 sum_ovf;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 ovf_next;

    // A new issue is allowed only when no frame end is pending and the slot can drain.
    assign i_ready   = (lastcnt_q == '0) & (~o_valid_q | o_ready);
    assign accept    = i_valid & i_ready;
    assign last_in   = accept & i_last;
    assign beat_in   = '{valid: accept, last: last_in};
    assign frame_end = beat_d.valid & beat_d.last;

    mult_valid_delay #(
        .DEPTH (LATENCY),
        .WIDTH (BEAT_W)
    ) u_delay (
        .clk    (clk),
        .rst    (arst),
        .data_i (beat_in),
        .data_o (beat_d)
    );

    // One-bit-wider add so overflow is the disagreement of the top two bits.
    always_comb begin
        p_ext    = {{(EXT_W-P_WIDTH){i_p[P_WIDTH-1]}}, i_p};
        base_ext = first_q ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
        sum_ext  = base_ext + p_ext;
        sum_ovf  = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
        acc_next = sum_ext[ACC_WIDTH-1:0];
        if (SAT_EN && sum_ovf) begin
            acc_next = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
        ovf_next = (first_q ? 1'b0 : ovf_q) | sum_ovf;
    end

    // Next-state for accumulator, frame tracking, in-flight count and result slot.
    always_comb begin
        acc_d     = acc_q;
        first_d   = first_q;
        ovf_d     = ovf_q;
        lastcnt_d = lastcnt_q + CNT_W'(last_in) - CNT_W'(frame_end);
        o_valid_d = o_valid_q;
        o_sum_d   = o_sum_q;
        o_ovf_d   = o_ovf_q;

        if (beat_d.valid) begin
            acc_d   = acc_next;
            ovf_d   = ovf_next;
            first_d = beat_d.last;
        end

        if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end

        if (frame_end) begin
            o_valid_d = 1'b1;
            o_sum_d   = acc_next;
            o_ovf_d   = ovf_next;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (arst) begin
            acc_q     <= '0;
            first_q   <= 1'b1;
            ovf_q     <= 1'b0;
            lastcnt_q <= '0;
            o_valid_q <= 1'b0;
            o_sum_q   <= '0;
            o_ovf_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            first_q   <= first_d;
            ovf_q     <= ovf_d;
            lastcnt_q <= lastcnt_d;
            o_valid_q <= o_valid_d;
            o_sum_q   <= o_sum_d;
            o_ovf_q   <= o_ovf_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_sum   = o_sum_q;
    assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench: two LATENCY=2 instances (saturating / wrapping) share stimulus,
// a third LATENCY=0 instance covers the back-to-back single-beat case.
module tb_mult_accumulator;

    localparam int unsigned P_W   = 7;
    localparam int unsigned ACC_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst;
    logic o_ready;

    // Shared LATENCY=2 stimulus with a two-stage multiplier model.
    logic              i_valid, i_last;
    logic signed [2:0] op_a, op_b;
    logic signed [6:0] prod_c, p_s1, p_s2;
    assign prod_c = 7'(op_a) * 7'(op_b);
    always @(posedge clk) begin
        p_s1 <= prod_c;
        p_s2 <= p_s1;
    end

    logic             rdy_sat, vld_sat, ovf_sat;
    logic [ACC_W-1:0] sum_sat;
    logic             rdy_wrp, vld_wrp, ovf_wrp;
    logic [ACC_W-1:0] sum_wrp;

    // LATENCY=0 stimulus with a combinational multiplier model.
    logic              l0_valid, l0_last;
    logic signed [2:0] l0_a, l0_b;
    logic signed [6:0] l0_p;
    assign l0_p = 7'(l0_a) * 7'(l0_b);

    logic             l0_rdy, l0_vld, l0_ovf;
    logic [ACC_W-1:0] l0_sum;

    mult_accumulator #(.P_WIDTH(P_W), .ACC_WIDTH(ACC_W), .LATENCY(2), .SATURATE("TRUE")) u_sat (
        .clk(clk), .arst(arst), .i_valid(i_valid), .i_last(i_last), .i_ready(rdy_sat),
        .i_p(p_s2), .o_valid(vld_sat), .o_ready(o_ready), .o_sum(sum_sat), .o_ovf(ovf_sat));

    mult_accumulator #(.P_WIDTH(P_W), .ACC_WIDTH(ACC_W), .LATENCY(2), .SATURATE("FALSE")) u_wrp (
        .clk(clk), .arst(arst), .i_valid(i_valid), .i_last(i_last), .i_ready(rdy_wrp),
        .i_p(p_s2), .o_valid(vld_wrp), .o_ready(o_ready), .o_sum(sum_wrp), .o_ovf(ovf_wrp));

    mult_accumulator #(.P_WIDTH(P_W), .ACC_WIDTH(ACC_W), .LATENCY(0), .SATURATE("FALSE")) u_l0 (
        .clk(clk), .arst(arst), .i_valid(l0_valid), .i_last(l0_last), .i_ready(l0_rdy),
        .i_p(l0_p), .o_valid(l0_vld), .o_ready(o_ready), .o_sum(l0_sum), .o_ovf(l0_ovf));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand pair, waiting (bounded) for i_ready.
    task automatic issue(input int a, input int b, input logic last);
        int n;
        n      = 0;
        op_a   = 3'(a);
        op_b   = 3'(b);
        i_valid = 1'b1;
        i_last  = last;
        while (!rdy_sat && n < 50) begin
            tick();
            n++;
        end
        if (!rdy_sat) check("issue_ready", 32'(rdy_sat), 32'd1);
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
        op_a    = '0;
        op_b    = '0;
    endtask

    // Wait (bounded) for the result slot of the shared-stimulus pair.
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!vld_sat && cyc < 30) begin
            tick();
            cyc++;
        end
        check("result_valid", 32'(vld_sat), 32'd1);
    endtask

    task automatic check_pair(input string tag, input logic [7:0] s_sat, input logic o_sat,
                              input logic [7:0] s_wrp, input logic o_wrp);
        check({tag, "_sum_sat"}, 32'(sum_sat), 32'(s_sat));
        check({tag, "_ovf_sat"}, 32'(ovf_sat), 32'(o_sat));
        check({tag, "_sum_wrp"}, 32'(sum_wrp), 32'(s_wrp));
        check({tag, "_ovf_wrp"}, 32'(ovf_wrp), 32'(o_wrp));
        check({tag, "_vld_wrp"}, 32'(vld_wrp), 32'd1);
    endtask

    int cyc;
    int l0_av [8] = '{1, -2, 3, -4, 2, 0, -1, 3};
    int l0_bv [8] = '{1, 3, 3, -4, -4, 3, -1, -4};
    logic [7:0] l0_exp [8] = '{8'h01, 8'hFA, 8'h09, 8'h10, 8'hF8, 8'h00, 8'h01, 8'hF4};

    initial begin
        arst = 1'b1; o_ready = 1'b1;
        i_valid = 1'b0; i_last = 1'b0; op_a = '0; op_b = '0;
        l0_valid = 1'b0; l0_last = 1'b0; l0_a = '0; l0_b = '0;
        repeat (3) tick();

        // Reset state.
        check("rst_vld", 32'(vld_sat), 32'd0);
        check("rst_sum", 32'(sum_sat), 32'd0);
        check("rst_ovf", 32'(ovf_wrp), 32'd0);
        arst = 1'b0;
        check("rst_rdy", 32'(rdy_sat), 32'd1);
        check("rst_rdy_l0", 32'(l0_rdy), 32'd1);

        // 1: 9 - 2 - 4 + 1 = 4, result three cycles after the last issue.
        issue(3, 3, 1'b0);
        issue(2, -1, 1'b0);
        issue(-4, 1, 1'b0);
        issue(1, 1, 1'b1);
        check("t1_rdy_blocked", 32'(rdy_sat), 32'd0);
        wait_result(cyc);
        check("t1_latency", 32'(cyc), 32'd2);
        check_pair("t1", 8'h04, 1'b0, 8'h04, 1'b0);

        // 2: single-beat frame -12, one-cycle-wide valid, then fresh frame from 0.
        tick();
        check("t1_vld_drop", 32'(vld_sat), 32'd0);
        issue(-4, 3, 1'b1);
        wait_result(cyc);
        check_pair("t2", 8'hF4, 1'b0, 8'hF4, 1'b0);
        tick();
        check("t2_vld_width", 32'(vld_sat), 32'd0);
        issue(2, 2, 1'b1);
        wait_result(cyc);
        check_pair("t2b", 8'h04, 1'b0, 8'h04, 1'b0);

        // 3: ten beats of +16 -> 160: clamp 127 / wrap -96.
        for (int i = 0; i < 10; i++) issue(-4, -4, i == 9);
        wait_result(cyc);
        check_pair("t3", 8'h7F, 1'b1, 8'hA0, 1'b1);

        // 3b: eleven beats of -12 -> -132: clamp -128 / wrap +124.
        for (int i = 0; i < 11; i++) issue(-4, 3, i == 10);
        wait_result(cyc);
        check_pair("t3b", 8'h80, 1'b1, 8'h7C, 1'b1);
        tick();

        // 4: consumer stalls ten cycles; slot and i_ready hold, then frame 2.
        o_ready = 1'b0;
        issue(3, 3, 1'b0);
        issue(1, 1, 1'b1);
        wait_result(cyc);
        for (int i = 0; i < 10; i++) begin
            check("t4_stall_rdy", 32'(rdy_sat), 32'd0);
            check("t4_stall_sum", 32'(sum_sat), 32'h0A);
            check("t4_stall_vld", 32'(vld_sat), 32'd1);
            tick();
        end
        o_ready = 1'b1;
        #1;
        check("t4_hs_rdy", 32'(rdy_sat), 32'd1);
        tick();
        check("t4_hs_vld", 32'(vld_sat), 32'd0);
        issue(2, 3, 1'b0);
        issue(1, -2, 1'b0);
        issue(3, 1, 1'b1);
        wait_result(cyc);
        check_pair("t4", 8'h07, 1'b0, 8'h07, 1'b0);
        tick();

        // 5: reset after two beats with one product still in flight.
        issue(1, 2, 1'b0);
        issue(2, 2, 1'b0);
        arst = 1'b1;
        tick();
        check("t5_vld", 32'(vld_sat), 32'd0);
        check("t5_sum", 32'(sum_sat), 32'd0);
        check("t5_ovf", 32'(ovf_sat), 32'd0);
        check("t5_rdy", 32'(rdy_sat), 32'd1);
        arst = 1'b0;
        repeat (3) tick();
        check("t5_no_ghost", 32'(vld_wrp), 32'd0);
        issue(1, 1, 1'b1);
        wait_result(cyc);
        check_pair("t5", 8'h01, 1'b0, 8'h01, 1'b0);
        tick();

        // 6: LATENCY=0, eight consecutive single-beat frames.
        for (int i = 0; i < 8; i++) begin
            l0_a     = 3'(l0_av[i]);
            l0_b     = 3'(l0_bv[i]);
            l0_valid = 1'b1;
            l0_last  = 1'b1;
            #1;
            check("t6_rdy", 32'(l0_rdy), 32'd1);
            tick();
            check("t6_vld", 32'(l0_vld), 32'd1);
            check("t6_sum", 32'(l0_sum), 32'(l0_exp[i]));
        end
        l0_valid = 1'b0;
        l0_last  = 1'b0;
        tick();
        check("t6_vld_end", 32'(l0_vld), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
